// File: rtl/lcd_write_sequencer.sv
// Drives a 4-bit HD44780-style character LCD: power-on init sequence, then byte writes
// accepted over valid/ready and sent as two timed, E-strobed nibbles.
module lcd_write_sequencer #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_LONG    = 82000,
  parameter int T_SETUP   = 2,
  parameter int T_EPULSE  = 12,
  parameter int T_HOLD    = 1,
  parameter int T_NIBBLE  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    STB_SETUP,
    STB_E,
    STB_HOLD,
    DELAY,
    IDLE
  } state_t;

  // Counter reload values: a state loaded with N-1 lasts N cycles.
  localparam logic [19:0] L_POWERUP = 20'(T_POWERUP - 2);
  localparam logic [19:0] L_INIT1   = 20'(T_INIT1 - 1);
  localparam logic [19:0] L_INIT2   = 20'(T_INIT2 - 1);
  localparam logic [19:0] L_CMD     = 20'(T_CMD - 1);
  localparam logic [19:0] L_LONG    = 20'(T_LONG - 1);
  localparam logic [19:0] L_SETUP   = 20'(T_SETUP - 1);
  localparam logic [19:0] L_EPULSE  = 20'(T_EPULSE - 1);
  localparam logic [19:0] L_HOLD    = 20'(T_HOLD - 1);
  localparam logic [19:0] L_NIBBLE  = 20'(T_NIBBLE - 1);

  state_t      state;
  logic [19:0] cnt;
  logic [2:0]  seq;
  logic        primed;
  logic [7:0]  data_q;
  logic        rs_q;
  logic        is_long;

  // Nibble steps: 0..3 are the init nibbles, 4 and 5 the high and low halves of a byte.
  function automatic logic [3:0] nibble_for(input logic [2:0] s, input logic [7:0] d);
    case (s)
      3'd0, 3'd1, 3'd2: nibble_for = 4'h3;
      3'd3:             nibble_for = 4'h2;
      3'd4:             nibble_for = d[7:4];
      default:          nibble_for = d[3:0];
    endcase
  endfunction

  function automatic logic [19:0] delay_for(input logic [2:0] s, input logic lng);
    case (s)
      3'd0:       delay_for = L_INIT1;
      3'd1:       delay_for = L_INIT2;
      3'd2, 3'd3: delay_for = L_CMD;
      3'd4:       delay_for = L_NIBBLE;
      default:    delay_for = lng ? L_LONG : L_CMD;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long settle time.
  assign is_long = !rs_q && (data_q[7:2] == 6'd0);
  assign LCD_RW  = 1'b0;

  always_ff @(posedge clk) begin
    if (state == IDLE && wr_valid) begin
      data_q <= wr_data;
      rs_q   <= wr_rs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PWR_WAIT;
      cnt       <= 20'd0;
      seq       <= 3'd0;
      primed    <= 1'b0;
      SF_D      <= 4'h0;
      LCD_E     <= 1'b0;
      LCD_RS    <= 1'b0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        PWR_WAIT: begin
          // The first cycle after reset loads the counter, so it holds T_POWERUP-2.
          if (primed || T_POWERUP == 1) begin
            if (cnt == 20'd0) begin
              state  <= STB_SETUP;
              seq    <= 3'd0;
              SF_D   <= 4'h3;
              LCD_RS <= 1'b0;
              cnt    <= L_SETUP;
            end else begin
              cnt <= cnt - 20'd1;
            end
          end else begin
            primed <= 1'b1;
            cnt    <= L_POWERUP;
          end
        end
        STB_SETUP: begin
          if (cnt == 20'd0) begin
            state <= STB_E;
            LCD_E <= 1'b1;
            cnt   <= L_EPULSE;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        STB_E: begin
          if (cnt == 20'd0) begin
            state <= STB_HOLD;
            LCD_E <= 1'b0;
            cnt   <= L_HOLD;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        STB_HOLD: begin
          if (cnt == 20'd0) begin
            state <= DELAY;
            cnt   <= delay_for(seq, is_long);
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        DELAY: begin
          if (cnt == 20'd0) begin
            if (seq == 3'd3 || seq == 3'd5) begin
              state     <= IDLE;
              wr_ready  <= 1'b1;
              SF_D      <= 4'h0;
              LCD_RS    <= 1'b0;
              init_done <= 1'b1;
            end else begin
              state <= STB_SETUP;
              seq   <= seq + 3'd1;
              SF_D  <= nibble_for(seq + 3'd1, data_q);
              cnt   <= L_SETUP;
            end
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        IDLE: begin
          if (wr_valid) begin
            state    <= STB_SETUP;
            seq      <= 3'd4;
            SF_D     <= wr_data[7:4];
            LCD_RS   <= wr_rs;
            wr_ready <= 1'b0;
            cnt      <= L_SETUP;
          end
        end
        default: begin
          state <= PWR_WAIT;
          cnt   <= 20'd0;
          LCD_E <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with shortened timing parameters.
module tb_lcd_write_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       init_done;
  logic [3:0] SF_D;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;

  int checks = 0;
  int errors = 0;

  // E-pulse log filled by the monitor below.
  int         e_count = 0;
  int         cur_len = 0;
  int         stb_bad = 0;
  int         rw_bad  = 0;
  logic       e_prev  = 1'b0;
  logic [3:0] nib_log [0:63];
  logic       rs_log  [0:63];
  int         len_log [0:63];

  lcd_write_sequencer #(
    .T_POWERUP(20), .T_INIT1(10), .T_INIT2(5), .T_CMD(4), .T_LONG(8),
    .T_SETUP(2), .T_EPULSE(3), .T_HOLD(1), .T_NIBBLE(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rs(wr_rs),
    .wr_data(wr_data), .init_done(init_done), .SF_D(SF_D), .LCD_E(LCD_E),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (LCD_RW !== 1'b0) rw_bad++;
    if (LCD_E === 1'b1) begin
      if (e_prev !== 1'b1) begin
        nib_log[e_count % 64] = SF_D;
        rs_log[e_count % 64]  = LCD_RS;
        cur_len = 1;
      end else begin
        cur_len++;
        if (SF_D !== nib_log[e_count % 64] || LCD_RS !== rs_log[e_count % 64]) stb_bad++;
      end
    end else if (e_prev === 1'b1) begin
      len_log[e_count % 64] = cur_len;
      e_count++;
    end
    e_prev = LCD_E;
  end

  task automatic wait_ready_low(output int lo);
    lo = 0;
    while (wr_ready !== 1'b1 && lo < 200) begin
      lo++;
      @(posedge clk); #1;
    end
  endtask

  task automatic release_and_time(output int n);
    @(negedge clk); rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (wr_ready !== 1'b1 && n < 300);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (SF_D !== 4'h0)    begin errors++; $display("FAIL reset_sf_d got %h want 0", SF_D); end
    checks++; if (LCD_E !== 1'b0)   begin errors++; $display("FAIL reset_e got %b want 0", LCD_E); end
    checks++; if (LCD_RS !== 1'b0)  begin errors++; $display("FAIL reset_rs got %b want 0", LCD_RS); end
    checks++; if (LCD_RW !== 1'b0)  begin errors++; $display("FAIL reset_rw got %b want 0", LCD_RW); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", wr_ready); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
  endtask

  task automatic test_init(input string tag);
    int n;
    int base;
    logic [3:0] exp_nib [0:3];
    exp_nib[0] = 4'h3; exp_nib[1] = 4'h3; exp_nib[2] = 4'h3; exp_nib[3] = 4'h2;
    base = e_count;
    release_and_time(n);
    checks++; if (n !== 67) begin errors++; $display("FAIL %s_latency got %0d want 67", tag, n); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL %s_init_done got %b want 1", tag, init_done); end
    checks++; if (e_count - base !== 4) begin errors++; $display("FAIL %s_pulses got %0d want 4", tag, e_count - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nib_log[(base + i) % 64] !== exp_nib[i] || rs_log[(base + i) % 64] !== 1'b0 ||
          len_log[(base + i) % 64] !== 3) begin
        errors++;
        $display("FAIL %s_nibble%0d got d=%h rs=%b len=%0d want d=%h rs=0 len=3", tag, i,
                 nib_log[(base + i) % 64], rs_log[(base + i) % 64], len_log[(base + i) % 64], exp_nib[i]);
      end
    end
    checks++; if (SF_D !== 4'h0 || LCD_RS !== 1'b0) begin errors++; $display("FAIL %s_idle_bus got d=%h rs=%b want 0 0", tag, SF_D, LCD_RS); end
  endtask

  task automatic send_byte(input string tag, input logic rs, input logic [7:0] d, input int exp_busy);
    int lo;
    int base;
    base = e_count;
    @(negedge clk); wr_valid = 1'b1; wr_rs = rs; wr_data = d;
    @(posedge clk); #1; wr_valid = 1'b0; wr_data = ~d; wr_rs = ~rs;
    wait_ready_low(lo);
    checks++; if (lo !== exp_busy) begin errors++; $display("FAIL %s_busy got %0d want %0d", tag, lo, exp_busy); end
    checks++; if (e_count - base !== 2) begin errors++; $display("FAIL %s_pulses got %0d want 2", tag, e_count - base); end
    checks++;
    if (nib_log[base % 64] !== d[7:4] || nib_log[(base + 1) % 64] !== d[3:0]) begin
      errors++;
      $display("FAIL %s_nibbles got %h %h want %h %h", tag, nib_log[base % 64], nib_log[(base + 1) % 64], d[7:4], d[3:0]);
    end
    checks++;
    if (rs_log[base % 64] !== rs || rs_log[(base + 1) % 64] !== rs ||
        len_log[base % 64] !== 3 || len_log[(base + 1) % 64] !== 3) begin
      errors++;
      $display("FAIL %s_rs_len got rs=%b%b len=%0d,%0d want rs=%b len=3", tag, rs_log[base % 64],
               rs_log[(base + 1) % 64], len_log[base % 64], len_log[(base + 1) % 64], rs);
    end
  endtask

  task automatic test_ignored_valid;
    int n;
    int base;
    int lo;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    base = e_count;
    @(negedge clk); rst = 1'b1;
    n = 0;
    repeat (5) begin @(posedge clk); n++; end
    @(negedge clk); wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'hFF;
    while (n < 60) begin @(posedge clk); n++; end
    @(negedge clk); wr_valid = 1'b0;
    #1;
    while (wr_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 67) begin errors++; $display("FAIL ign_init_latency got %0d want 67", n); end
    checks++;
    if (e_count - base !== 4 || nib_log[(base + 3) % 64] !== 4'h2 || rs_log[(base + 3) % 64] !== 1'b0) begin
      errors++;
      $display("FAIL ign_init_pulses got n=%0d last=%h rs=%b want n=4 last=2 rs=0", e_count - base,
               nib_log[(base + 3) % 64], rs_log[(base + 3) % 64]);
    end
    base = e_count;
    @(negedge clk); wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h48;
    @(posedge clk); #1; wr_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); wr_valid = 1'b1; wr_rs = 1'b0; wr_data = 8'h13;
    repeat (8) @(posedge clk);
    @(negedge clk); wr_valid = 1'b0;
    #1;
    wait_ready_low(lo);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (e_count - base !== 2 || nib_log[base % 64] !== 4'h4 || nib_log[(base + 1) % 64] !== 4'h8 ||
        rs_log[(base + 1) % 64] !== 1'b1) begin
      errors++;
      $display("FAIL ign_mid_byte got n=%0d d=%h%h rs=%b want n=2 d=48 rs=1", e_count - base,
               nib_log[base % 64], nib_log[(base + 1) % 64], rs_log[(base + 1) % 64]);
    end
  endtask

  task automatic test_back_to_back;
    int lo1;
    int lo2;
    int base;
    base = e_count;
    @(negedge clk); wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
    @(posedge clk); #1; wr_data = 8'h42;
    wait_ready_low(lo1);
    @(posedge clk); #1; wr_valid = 1'b0;
    wait_ready_low(lo2);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (lo1 !== 18) begin errors++; $display("FAIL b2b_busy1 got %0d want 18", lo1); end
    checks++; if (lo2 !== 18) begin errors++; $display("FAIL b2b_busy2 got %0d want 18", lo2); end
    checks++; if (e_count - base !== 4) begin errors++; $display("FAIL b2b_pulses got %0d want 4", e_count - base); end
    checks++;
    if (nib_log[base % 64] !== 4'h4 || nib_log[(base + 1) % 64] !== 4'h1 ||
        nib_log[(base + 2) % 64] !== 4'h4 || nib_log[(base + 3) % 64] !== 4'h2 ||
        rs_log[(base + 2) % 64] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_nibbles got %h%h %h%h want 41 42", nib_log[base % 64], nib_log[(base + 1) % 64],
               nib_log[(base + 2) % 64], nib_log[(base + 3) % 64]);
    end
  endtask

  task automatic test_async_reset;
    int w;
    @(negedge clk); wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h5A;
    @(posedge clk); #1; wr_valid = 1'b0;
    w = 0;
    while (LCD_E !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    checks++; if (LCD_E !== 1'b1) begin errors++; $display("FAIL arst_find_e got %b want 1", LCD_E); end
    #4; rst = 1'b0; #1;
    checks++; if (LCD_E !== 1'b0) begin errors++; $display("FAIL arst_e got %b want 0", LCD_E); end
    checks++; if (wr_ready !== 1'b0 || init_done !== 1'b0 || SF_D !== 4'h0) begin
      errors++; $display("FAIL arst_state got ready=%b done=%b d=%h want 0 0 0", wr_ready, init_done, SF_D);
    end
    repeat (3) @(posedge clk);
    #1;
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    send_byte("data48", 1'b1, 8'h48, 18);
    send_byte("clear01", 1'b0, 8'h01, 22);
    send_byte("cmd0c", 1'b0, 8'h0C, 18);
    test_ignored_valid();
    test_back_to_back();
    test_async_reset();
    checks++; if (stb_bad !== 0) begin errors++; $display("FAIL strobe_stable got %0d want 0", stb_bad); end
    checks++; if (rw_bad !== 0)  begin errors++; $display("FAIL rw_zero got %0d want 0", rw_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
